// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared types, size codes and load-extension helpers for mem_arbiter
package mem_arbiter_pkg;

  localparam logic [63:0] PMEM_START         = 64'h8000_0000;
  localparam int unsigned STARVE_MAX_DEFAULT = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RSP  = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_e;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;
  localparam logic [1:0] SIZE_D = 2'd3;

  function automatic logic [63:0] sext(input logic [63:0] v, input logic [1:0] size);
    case (size)
      SIZE_B:  return {{56{v[7]}}, v[7:0]};
      SIZE_H:  return {{48{v[15]}}, v[15:0]};
      SIZE_W:  return {{32{v[31]}}, v[31:0]};
      default: return v;
    endcase
  endfunction

  function automatic logic [63:0] zext(input logic [63:0] v, input logic [1:0] size);
    case (size)
      SIZE_B:  return {56'd0, v[7:0]};
      SIZE_H:  return {48'd0, v[15:0]};
      SIZE_W:  return {32'd0, v[31:0]};
      default: return v;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_ext.sv
// rtl/mem_load_ext.sv - funct3-driven sign/zero extension of raw memory read data
module mem_load_ext
  import mem_arbiter_pkg::*;
(
  input  logic [63:0] rdata_i,
  input  logic [2:0]  funct3_i,
  output logic [63:0] data_o
);

  always_comb begin
    data_o = funct3_i[2] ? zext(rdata_i, funct3_i[1:0]) : sext(rdata_i, funct3_i[1:0]);
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-port memory arbiter for ifetch and load/store requesters
// Define MEM_ARB_FAIR_EN to bound ifetch starvation with a consecutive-data-grant counter.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter logic [63:0] ADDR_BASE = PMEM_START
`ifdef MEM_ARB_FAIR_EN
  ,
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEFAULT
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req_i,
  input  logic [63:0] if_addr_i,
  output logic        if_gnt_o,
  output logic        if_rvalid_o,
  output logic [31:0] if_rdata_o,
  input  logic        d_req_i,
  input  logic        d_we_i,
  input  logic [2:0]  d_funct3_i,
  input  logic [63:0] d_addr_i,
  input  logic [63:0] d_wdata_i,
  output logic        d_gnt_o,
  output logic        d_rvalid_o,
  output logic [63:0] d_rdata_o,
  output logic        m_req_o,
  output logic        m_we_o,
  output logic [63:0] m_addr_o,
  output logic [1:0]  m_size_o,
  output logic [63:0] m_wdata_o,
  input  logic        m_ready_i,
  input  logic        m_rvalid_i,
  input  logic [63:0] m_rdata_i
);

  arb_state_e  state_q, state_d;
  owner_e      owner_q, owner_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic [2:0]  funct3_q, funct3_d;
  logic        we_q, we_d;
  logic        pick_data;
  logic        force_if;
  logic        in_req, in_rsp;
  logic [63:0] ext_data;

`ifdef MEM_ARB_FAIR_EN
  localparam int unsigned     CNT_W      = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] starve_q, starve_d;

  always_comb begin
    starve_d = starve_q;
    if (!if_req_i || if_gnt_o) begin
      starve_d = '0;
    end else if (d_gnt_o && starve_q != STARVE_LIM) begin
      starve_d = starve_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

  assign force_if = if_req_i && (starve_q == STARVE_LIM);
`else
  assign force_if = 1'b0;
`endif

  assign pick_data = d_req_i && !force_if;

  // Ifetch is encoded as an unsigned word access so the latched funct3 also supplies m_size_o.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    funct3_d = funct3_q;
    we_d     = we_q;
    case (state_q)
      ST_IDLE: begin
        if (d_req_i || if_req_i) begin
          state_d = ST_REQ;
          if (pick_data) begin
            owner_d  = OWN_D;
            addr_d   = d_addr_i - ADDR_BASE;
            wdata_d  = d_wdata_i;
            funct3_d = d_funct3_i;
            we_d     = d_we_i;
          end else begin
            owner_d  = OWN_IF;
            addr_d   = if_addr_i - ADDR_BASE;
            wdata_d  = 64'd0;
            funct3_d = {1'b1, SIZE_W};
            we_d     = 1'b0;
          end
        end
      end
      ST_REQ: begin
        if (m_ready_i) state_d = ST_RSP;
      end
      ST_RSP: begin
        if (m_rvalid_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      owner_q  <= OWN_IF;
      addr_q   <= 64'd0;
      wdata_q  <= 64'd0;
      funct3_q <= 3'd0;
      we_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      funct3_q <= funct3_d;
      we_q     <= we_d;
    end
  end

  mem_load_ext u_load_ext (
    .rdata_i  (m_rdata_i),
    .funct3_i (funct3_q),
    .data_o   (ext_data)
  );

  assign in_req = (state_q == ST_REQ);
  assign in_rsp = (state_q == ST_RSP);

  // Memory-port fields are only presented while a request is outstanding.
  assign m_req_o   = in_req;
  assign m_we_o    = in_req && we_q;
  assign m_addr_o  = in_req ? addr_q : 64'd0;
  assign m_size_o  = in_req ? funct3_q[1:0] : 2'd0;
  assign m_wdata_o = in_req ? wdata_q : 64'd0;

  assign if_gnt_o    = in_req && m_ready_i && (owner_q == OWN_IF);
  assign d_gnt_o     = in_req && m_ready_i && (owner_q == OWN_D);
  assign if_rvalid_o = in_rsp && m_rvalid_i && (owner_q == OWN_IF);
  assign d_rvalid_o  = in_rsp && m_rvalid_i && (owner_q == OWN_D);

  assign if_rdata_o = if_rvalid_o ? m_rdata_i[31:0] : 32'd0;
  assign d_rdata_o  = (d_rvalid_o && !we_q) ? ext_data : 64'd0;

endmodule
